cp0_intc: RTL and testbench

//  Parametrised coprocessor-0 for the multi-cycle MIPS core: SR, Cause, EPC, PRId.

---
 rtl/cp0_intc.sv | 173 +++++++++++++++++
 tb/tb_cp0_intc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_intc.sv
// cp0_intc: MIPS coprocessor-0 (SR, Cause, EPC, PRId) with hw interrupt sync and priority.
// Optional Count/Compare timer is built in when CP0_TIMER_EN is defined.
module cp0_intc #(
   parameter int unsigned DEV_CNT = 6,
   parameter logic [31:0] PRID    = 32'h0000_1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [29:0]        pc,
   input  logic [31:0]        din,
   input  logic [4:0]         sel,
   input  logic               wen,
   input  logic               exl_set,
   input  logic               exl_clr,
   input  logic [DEV_CNT-1:0] hw_int,
   output logic               int_req,
   output logic [29:0]        epc,
   output logic [31:0]        dout
);

`ifdef CP0_TIMER_EN
   localparam int unsigned NI = DEV_CNT + 1;
`else
   localparam int unsigned NI = DEV_CNT;
`endif

   localparam logic [4:0] SEL_COUNT = 5'd9;
   localparam logic [4:0] SEL_CMP   = 5'd11;
   localparam logic [4:0] SEL_SR    = 5'd12;
   localparam logic [4:0] SEL_CAUSE = 5'd13;
   localparam logic [4:0] SEL_EPC   = 5'd14;
   localparam logic [4:0] SEL_PRID  = 5'd15;

   logic [DEV_CNT-1:0] sync_q, sync_d;
   logic [DEV_CNT-1:0] ip_q, ip_d;
   logic [NI-1:0]      im_q, im_d;
   logic               exl_q, exl_d;
   logic               ie_q, ie_d;
   logic [29:0]        epc_q, epc_d;
   logic [4:0]         exc_q, exc_d;

   logic [NI-1:0] src;
   logic [NI-1:0] pend;
   logic [4:0]    win;
   logic          wr_sr;
   logic          wr_epc;
   logic [31:0]   sr_rd;
   logic [31:0]   cause_rd;

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_q, ti_d;

   // Compare write clears TI even if the match fires in the same cycle
   always_comb begin
      count_d   = count_q + 32'd1;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (count_q == compare_q && compare_q != 32'd0)
         ti_d = 1'b1;
      if (wen && sel == SEL_COUNT)
         count_d = din;
      if (wen && sel == SEL_CMP) begin
         compare_d = din;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign src = {ti_q, ip_q};
`else
   assign src = ip_q;
`endif

   assign pend = src & im_q;

   // lowest index wins
   always_comb begin
      win = '0;
      for (int i = NI - 1; i >= 0; i--)
         if (pend[i])
            win = 5'(i);
   end

   assign wr_sr  = wen && (sel == SEL_SR);
   assign wr_epc = wen && (sel == SEL_EPC);

   // later assignments take priority: wen < exl_clr < exl_set
   always_comb begin
      sync_d = hw_int;
      ip_d   = sync_q;
      im_d   = im_q;
      ie_d   = ie_q;
      exl_d  = exl_q;
      epc_d  = epc_q;
      exc_d  = exc_q;
      if (wr_sr) begin
         im_d  = din[10 +: NI];
         exl_d = din[1];
         ie_d  = din[0];
      end
      if (wr_epc)
         epc_d = din[31:2];
      if (exl_clr)
         exl_d = 1'b0;
      if (exl_set) begin
         exl_d = 1'b1;
         epc_d = pc;
         exc_d = win;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         ip_q   <= '0;
         im_q   <= '0;
         ie_q   <= 1'b0;
         exl_q  <= 1'b0;
         epc_q  <= '0;
         exc_q  <= '0;
      end else begin
         sync_q <= sync_d;
         ip_q   <= ip_d;
         im_q   <= im_d;
         ie_q   <= ie_d;
         exl_q  <= exl_d;
         epc_q  <= epc_d;
         exc_q  <= exc_d;
      end
   end

   assign int_req = (|pend) & ie_q & ~exl_q;
   assign epc     = epc_q;

   always_comb begin
      sr_rd           = '0;
      sr_rd[10 +: NI] = im_q;
      sr_rd[1]        = exl_q;
      sr_rd[0]        = ie_q;
      cause_rd           = '0;
      cause_rd[10 +: NI] = src;
      cause_rd[6:2]      = exc_q;
   end

   always_comb begin
      dout = '0;
      case (sel)
`ifdef CP0_TIMER_EN
         SEL_COUNT: dout = count_q;
         SEL_CMP:   dout = compare_q;
`endif
         SEL_SR:    dout = sr_rd;
         SEL_CAUSE: dout = cause_rd;
         SEL_EPC:   dout = {epc_q, 2'b00};
         SEL_PRID:  dout = PRID;
         default:   dout = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed self-checking bench for cp0_intc (DEV_CNT=6).
// Timer steps are compiled in when CP0_TIMER_EN is defined.
module tb_cp0_intc;

   logic        clk;
   logic        rst;
   logic [29:0] pc;
   logic [31:0] din;
   logic [4:0]  sel;
   logic        wen;
   logic        exl_set;
   logic        exl_clr;
   logic [5:0]  hw_int;
   logic        int_req;
   logic [29:0] epc;
   logic [31:0] dout;

   int n_chk;
   int n_fail;

   cp0_intc #(.DEV_CNT(6), .PRID(32'h0000_1000)) dut (
      .clk     (clk),
      .rst     (rst),
      .pc      (pc),
      .din     (din),
      .sel     (sel),
      .wen     (wen),
      .exl_set (exl_set),
      .exl_clr (exl_clr),
      .hw_int  (hw_int),
      .int_req (int_req),
      .epc     (epc),
      .dout    (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rdchk(input string tag, input logic [4:0] s,
                        input logic [31:0] exp);
      sel = s;
      #1;
      chk(tag, dout, exp);
   endtask

   task automatic wr(input logic [4:0] s, input logic [31:0] d);
      sel = s;
      din = d;
      wen = 1'b1;
      tick();
      wen = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b0;
      pc = '0;
      din = '0;
      sel = '0;
      wen = 1'b0;
      exl_set = 1'b0;
      exl_clr = 1'b0;
      hw_int = '0;
      tick();
      tick();
      rdchk("rst_sr", 5'd12, 32'h0);
      chk("rst_epc", 32'(epc), 32'h0);
      chk("rst_req", 32'(int_req), 32'h0);
      rst = 1'b1;
      tick();

      // IE=1, IM[0] only; line 1 is masked
      wr(5'd12, 32'h0000_0401);
      rdchk("sr_wr", 5'd12, 32'h0000_0401);
      hw_int = 6'b000010;
      tick();
      tick();
      tick();
      chk("im_mask", 32'(int_req), 32'h0);
      rdchk("ip_masked", 5'd13, 32'h0000_0800);

      // latency: high before edge k -> request after edge k+1
      hw_int = 6'b000011;
      tick();
      chk("lat_k", 32'(int_req), 32'h0);
      tick();
      chk("lat_k1", 32'(int_req), 32'h1);
      tick();
      hw_int = 6'b000000;
      tick();
      tick();
      chk("drop", 32'(int_req), 32'h0);

      // exception entry and eret
      wr(5'd12, 32'h0000_FC01);
      hw_int = 6'b000110;
      tick();
      tick();
      chk("pend", 32'(int_req), 32'h1);
      pc = 30'h0C00;
      exl_set = 1'b1;
      tick();
      exl_set = 1'b0;
      chk("exl_epc", 32'(epc), 32'h0000_0C00);
      chk("exl_req", 32'(int_req), 32'h0);
      rdchk("exl_cause", 5'd13, 32'h0000_1804);
      rdchk("exl_sr", 5'd12, 32'h0000_FC03);
      tick();
      chk("exl_hold", 32'(int_req), 32'h0);
      exl_clr = 1'b1;
      tick();
      exl_clr = 1'b0;
      chk("eret", 32'(int_req), 32'h1);

      // simultaneous strobes
      pc = 30'h2345;
      exl_set = 1'b1;
      exl_clr = 1'b1;
      wen = 1'b1;
      sel = 5'd14;
      din = 32'h0000_1234;
      tick();
      exl_set = 1'b0;
      exl_clr = 1'b0;
      wen = 1'b0;
      chk("sim_epc", 32'(epc), 32'h0000_2345);
      rdchk("sim_sr", 5'd12, 32'h0000_FC03);

      pc = 30'h0100;
      exl_set = 1'b1;
      wen = 1'b1;
      sel = 5'd12;
      din = 32'h0000_0401;
      tick();
      exl_set = 1'b0;
      wen = 1'b0;
      rdchk("set_wsr", 5'd12, 32'h0000_0403);
      chk("set_wepc", 32'(epc), 32'h0000_0100);

      exl_clr = 1'b1;
      wen = 1'b1;
      sel = 5'd12;
      din = 32'h0000_FC03;
      tick();
      exl_clr = 1'b0;
      wen = 1'b0;
      rdchk("clr_wsr", 5'd12, 32'h0000_FC01);
      chk("clr_req", 32'(int_req), 32'h1);

      wr(5'd14, 32'h0000_1234);
      rdchk("epc_wr", 5'd14, 32'h0000_1234);
      chk("epc_out", 32'(epc), 32'h0000_048D);

      // read-only / unmapped registers
      wr(5'd13, 32'hFFFF_FFFF);
      rdchk("cause_ro", 5'd13, 32'h0000_1804);
      wr(5'd15, 32'hFFFF_FFFF);
      rdchk("prid", 5'd15, 32'h0000_1000);
      rdchk("unmapped", 5'd3, 32'h0);
`ifndef CP0_TIMER_EN
      wr(5'd9, 32'h0000_0005);
      rdchk("no_count", 5'd9, 32'h0);
      wr(5'd11, 32'h0000_0005);
      rdchk("no_cmp", 5'd11, 32'h0);
`endif

      // priority: lines 3 and 5 pending -> ExcCode 3
      hw_int = 6'b101000;
      tick();
      tick();
      pc = 30'h0200;
      exl_set = 1'b1;
      tick();
      exl_set = 1'b0;
      rdchk("prio", 5'd13, 32'h0000_A00C);

      // reset in the middle of a pending request
      exl_clr = 1'b1;
      tick();
      exl_clr = 1'b0;
      chk("pre_rst", 32'(int_req), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_req", 32'(int_req), 32'h0);
      chk("mid_epc", 32'(epc), 32'h0);
      rdchk("mid_sr", 5'd12, 32'h0);
      rdchk("mid_cause", 5'd13, 32'h0);
      tick();
      hw_int = '0;
      rst = 1'b1;
      tick();
      tick();

`ifdef CP0_TIMER_EN
      wr(5'd12, 32'h0001_0001);
      wr(5'd9, 32'hFFFF_FFFE);
      rdchk("cnt_ld", 5'd9, 32'hFFFF_FFFE);
      wr(5'd11, 32'h0000_0001);
      rdchk("cnt_inc", 5'd9, 32'hFFFF_FFFF);
      rdchk("ti_off", 5'd13, 32'h0);
      tick();
      rdchk("cnt_wrap", 5'd9, 32'h0);
      tick();
      chk("ti_wait", 32'(int_req), 32'h0);
      tick();
      rdchk("ti_set", 5'd13, 32'h0001_0000);
      chk("ti_req", 32'(int_req), 32'h1);
      wr(5'd11, 32'h0000_0000);
      rdchk("ti_clr", 5'd13, 32'h0);
      chk("ti_clr_req", 32'(int_req), 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
